// File: rtl/isa_pkg.sv
// isa_pkg: shared RV32I subset definitions for the instruction encoder/loader.
//   op_e      - 4-bit symbolic operation codes (13..15 are illegal)
//   OPC_*     - 7-bit major opcodes
//   F3_*/F7_* - funct3/funct7 field values
//   NOP       - addi x0,x0,0, written in place of illegal operations
package isa_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLLI = 4'd5,
    OP_SRLI = 4'd6,
    OP_ANDI = 4'd7,
    OP_ADDI = 4'd8,
    OP_LBU  = 4'd9,
    OP_SB   = 4'd10,
    OP_BNE  = 4'd11,
    OP_JAL  = 4'd12
  } op_e;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRL = 3'b101;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/instr_encode.sv
// instr_encode: combinational encoder from a symbolic request to an RV32I word.
//   op          in  4   operation code (op_e; 13..15 illegal)
//   rd/rs1/rs2  in  5   register indices (unused fields are forced to 0)
//   imm         in  32  signed immediate, or shift amount for slli/srli
//   word        out 32  encoded instruction (NOP for illegal op)
//   err_imm     out 1   immediate outside the field's legal range
//   err_illegal out 1   op not in the supported subset
module instr_encode
  import isa_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        err_imm,
  output logic        err_illegal
);

  logic fits_i;
  logic fits_b;
  logic fits_j;
  logic fits_sh;

  // A signed value fits an N-bit field when every bit above the field's
  // sign bit matches it; B/J offsets must also be halfword aligned.
  assign fits_i  = (&imm[31:11]) || !(|imm[31:11]);
  assign fits_b  = ((&imm[31:12]) || !(|imm[31:12])) && !imm[0];
  assign fits_j  = ((&imm[31:20]) || !(|imm[31:20])) && !imm[0];
  assign fits_sh = !(|imm[31:5]);

  always_comb begin
    word        = NOP;
    err_imm     = 1'b0;
    err_illegal = 1'b0;
    case (op)
      OP_ADD:  word = {F7_BASE, rs2, rs1, F3_ADD, rd, OPC_R};
      OP_SUB:  word = {F7_SUB,  rs2, rs1, F3_ADD, rd, OPC_R};
      OP_AND:  word = {F7_BASE, rs2, rs1, F3_AND, rd, OPC_R};
      OP_OR:   word = {F7_BASE, rs2, rs1, F3_OR,  rd, OPC_R};
      OP_XOR:  word = {F7_BASE, rs2, rs1, F3_XOR, rd, OPC_R};
      OP_SLLI: begin
        word    = {F7_BASE, imm[4:0], rs1, F3_SLL, rd, OPC_I_ALU};
        err_imm = !fits_sh;
      end
      OP_SRLI: begin
        word    = {F7_BASE, imm[4:0], rs1, F3_SRL, rd, OPC_I_ALU};
        err_imm = !fits_sh;
      end
      OP_ANDI: begin
        word    = {imm[11:0], rs1, F3_AND, rd, OPC_I_ALU};
        err_imm = !fits_i;
      end
      OP_ADDI: begin
        word    = {imm[11:0], rs1, F3_ADD, rd, OPC_I_ALU};
        err_imm = !fits_i;
      end
      OP_LBU: begin
        word    = {imm[11:0], rs1, F3_LBU, rd, OPC_LOAD};
        err_imm = !fits_i;
      end
      OP_SB: begin
        word    = {imm[11:5], rs2, rs1, F3_SB, imm[4:0], OPC_STORE};
        err_imm = !fits_i;
      end
      OP_BNE: begin
        word    = {imm[12], imm[10:5], rs2, rs1, F3_BNE, imm[4:1], imm[11], OPC_BRANCH};
        err_imm = !fits_b;
      end
      OP_JAL: begin
        word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
        err_imm = !fits_j;
      end
      default: err_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes symbolic requests and writes them, one word
// per completed write, into instruction memory as a framed test program.
//   clk, rst_n              clock / async active-low reset
//   start                   pulse: begin a program at BASE_ADDR
//   req_valid/req_ready     request handshake
//   req_op/rd/rs1/rs2/imm   symbolic instruction; req_last ends the program
//   mem_we/mem_ready        write handshake (held until accepted)
//   mem_addr/mem_wdata      byte address / encoded word
//   done, count             program complete / words written
//   err_illegal/imm/full    sticky error flags, cleared by start
//
// state | meaning
// IDLE  | after reset, waiting for start
// LOAD  | accepting requests, writing words
// DONE  | program finished (last word or MAX_WORDS written), waiting for start
module instr_encoder_loader
  import isa_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    MAX_WORDS  = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [3:0]                    req_op,
  input  logic [4:0]                    req_rd,
  input  logic [4:0]                    req_rs1,
  input  logic [4:0]                    req_rs2,
  input  logic [31:0]                   req_imm,
  input  logic                          req_last,
  output logic                          mem_we,
  input  logic                          mem_ready,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [31:0]                   mem_wdata,
  output logic                          done,
  output logic [$clog2(MAX_WORDS+1)-1:0] count,
  output logic                          err_illegal,
  output logic                          err_imm,
  output logic                          err_full
);

  localparam int CW = $clog2(MAX_WORDS+1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_e;

  state_e        state;
  logic          pend_last;
  logic          pend_full;
  logic [31:0]   enc_word;
  logic          enc_err_imm;
  logic          enc_err_ill;
  logic          wr_done;
  logic          accept;
  logic [CW-1:0] words_after;

  instr_encode u_enc (
    .op          (req_op),
    .rd          (req_rd),
    .rs1         (req_rs1),
    .rs2         (req_rs2),
    .imm         (req_imm),
    .word        (enc_word),
    .err_imm     (enc_err_imm),
    .err_illegal (enc_err_ill)
  );

  assign wr_done   = mem_we && mem_ready;
  // Once the closing word sits in the output register nothing more is taken.
  assign req_ready = (state == S_LOAD) && (!mem_we || mem_ready) && !(pend_last || pend_full);
  assign accept    = req_valid && req_ready;
  // Count the newly accepted word will produce when its own write completes.
  assign words_after = count + CW'(wr_done) + CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      mem_we      <= 1'b0;
      mem_addr    <= BASE_ADDR;
      mem_wdata   <= '0;
      pend_last   <= 1'b0;
      pend_full   <= 1'b0;
      count       <= '0;
      done        <= 1'b0;
      err_illegal <= 1'b0;
      err_imm     <= 1'b0;
      err_full    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state       <= S_LOAD;
            mem_addr    <= BASE_ADDR;
            count       <= '0;
            done        <= 1'b0;
            pend_last   <= 1'b0;
            pend_full   <= 1'b0;
            err_illegal <= 1'b0;
            err_imm     <= 1'b0;
            err_full    <= 1'b0;
          end
        end
        S_LOAD: begin
          if (wr_done) begin
            mem_we   <= 1'b0;
            count    <= count + CW'(1);
            mem_addr <= mem_addr + ADDR_WIDTH'(4);
            if (pend_last || pend_full) begin
              state     <= S_DONE;
              done      <= 1'b1;
              pend_last <= 1'b0;
              pend_full <= 1'b0;
              if (!pend_last) err_full <= 1'b1;
            end
          end
          if (accept) begin
            mem_we      <= 1'b1;
            mem_wdata   <= enc_word;
            pend_last   <= req_last;
            pend_full   <= (words_after == CW'(MAX_WORDS));
            err_illegal <= err_illegal | enc_err_ill;
            err_imm     <= err_imm | enc_err_imm;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;

  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [4:0]  req_rd, req_rs1, req_rs2;
  logic [31:0] req_imm;
  logic        req_last;
  logic        mem_we;
  logic        mem_ready;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        done;
  logic [2:0]  count;
  logic        err_illegal, err_imm, err_full;

  int checks = 0;
  int errors = 0;

  instr_encoder_loader #(.ADDR_WIDTH(8), .BASE_ADDR(8'h00), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .req_last(req_last), .mem_we(mem_we), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .done(done), .count(count),
    .err_illegal(err_illegal), .err_imm(err_imm), .err_full(err_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [31:0] word;
    logic        ill, bad;
  } vec_t;

  vec_t vt[16];

  int p_op[8], p_rd[8], p_rs1[8], p_rs2[8], p_imm[8];
  bit p_last[8];
  int p_n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference encoder: field placement by arithmetic, ranges as integer bounds.
  function automatic void model_enc(input int op, input int rd, input int rs1, input int rs2,
                                    input int imm, output logic [31:0] w,
                                    output bit ill, output bit bad);
    logic [31:0] u, r, s1, s2;
    int f3;
    u = imm; r = rd; s1 = rs1; s2 = rs2;
    ill = 0; bad = 0; w = 32'h13;
    case (op)
      0, 1, 2, 3, 4: begin
        f3 = (op == 2) ? 7 : (op == 3) ? 6 : (op == 4) ? 4 : 0;
        w = ((op == 1) ? 32'h4000_0000 : 32'h0) | (s2 << 20) | (s1 << 15)
            | (32'(f3) << 12) | (r << 7) | 32'h33;
      end
      5, 6: begin
        bad = (imm < 0) || (imm > 31);
        w = ((u % 32) << 20) | (s1 << 15) | ((op == 5) ? 32'h1000 : 32'h5000) | (r << 7) | 32'h13;
      end
      7, 8, 9: begin
        bad = (imm < -2048) || (imm > 2047);
        f3 = (op == 7) ? 7 : (op == 8) ? 0 : 4;
        w = ((u % 4096) << 20) | (s1 << 15) | (32'(f3) << 12) | (r << 7)
            | ((op == 9) ? 32'h03 : 32'h13);
      end
      10: begin
        bad = (imm < -2048) || (imm > 2047);
        w = (((u / 32) % 128) << 25) | (s2 << 20) | (s1 << 15) | ((u % 32) << 7) | 32'h23;
      end
      11: begin
        bad = (imm < -4096) || (imm > 4094) || (imm % 2 != 0);
        w = (((u / 4096) % 2) << 31) | (((u / 32) % 64) << 25) | (s2 << 20) | (s1 << 15)
            | 32'h1000 | (((u / 2) % 16) << 8) | (((u / 2048) % 2) << 7) | 32'h63;
      end
      12: begin
        bad = (imm < -1048576) || (imm > 1048574) || (imm % 2 != 0);
        w = (((u / 1048576) % 2) << 31) | (((u / 2) % 1024) << 21) | (((u / 2048) % 2) << 20)
            | (((u / 4096) % 256) << 12) | (r << 7) | 32'h6F;
      end
      default: ill = 1;
    endcase
  endfunction

  function automatic int rand_imm();
    int b[12] = '{-2049, -2048, 2047, 2048, 31, 32, -4096, 4094, 4095,
                  -1048576, 1048574, 1048576};
    case ($urandom_range(2))
      0:       return int'($urandom_range(64)) - 32;
      1:       return b[$urandom_range(11)];
      default: return int'($urandom);
    endcase
  endfunction

  task automatic set_req(input int op, input int rd, input int rs1, input int rs2,
                         input int imm, input bit last);
    req_op = 4'(op); req_rd = 5'(rd); req_rs1 = 5'(rs1); req_rs2 = 5'(rs2);
    req_imm = imm; req_last = last;
  endtask

  task automatic do_start();
    @(negedge clk);
    req_valid = 0;
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  // Runs the program in p_* with random valid gaps and mem_ready stalls,
  // checking every write, hold behaviour and the final status.
  task automatic run_program(input int rdy_pct);
    int idx, n_wr, exp_n;
    bit has_last, done_seen, hold, e_ill, e_imm, ei, eb;
    logic [31:0] w, h_data;
    logic [7:0]  h_addr;
    logic [31:0] q_word[$];
    logic [7:0]  q_addr[$];
    exp_n = MAXW; has_last = 0; e_ill = 0; e_imm = 0;
    for (int i = 0; i < p_n && i < MAXW; i++)
      if (p_last[i] && !has_last) begin exp_n = i + 1; has_last = 1; end
    for (int i = 0; i < exp_n; i++) begin
      model_enc(p_op[i], p_rd[i], p_rs1[i], p_rs2[i], p_imm[i], w, ei, eb);
      e_ill |= ei; e_imm |= eb;
    end
    do_start();
    idx = 0; n_wr = 0; done_seen = 0; hold = 0; h_data = 0; h_addr = 0;
    for (int cyc = 0; cyc < 300 && !done_seen; cyc++) begin
      @(negedge clk);
      mem_ready = ($urandom_range(99) < rdy_pct);
      if (idx < p_n && $urandom_range(3) != 0) begin
        set_req(p_op[idx], p_rd[idx], p_rs1[idx], p_rs2[idx], p_imm[idx], p_last[idx]);
        req_valid = 1;
      end else req_valid = 0;
      #1;
      if (hold && mem_we) begin
        chk("hold_addr", 32'(mem_addr), 32'(h_addr));
        chk("hold_data", mem_wdata, h_data);
      end
      hold = mem_we && !mem_ready; h_addr = mem_addr; h_data = mem_wdata;
      if (mem_we && mem_ready) begin
        if (q_word.size() == 0) chk("unexpected_write", 32'(n_wr), 32'(exp_n));
        else begin
          chk("wr_addr", 32'(mem_addr), 32'(q_addr.pop_front()));
          chk("wr_word", mem_wdata, q_word.pop_front());
        end
        n_wr++;
      end
      if (req_valid && req_ready) begin
        if (idx >= exp_n) chk("accept_after_stop", 32'(idx), 32'(exp_n - 1));
        model_enc(p_op[idx], p_rd[idx], p_rs1[idx], p_rs2[idx], p_imm[idx], w, ei, eb);
        q_word.push_back(w);
        q_addr.push_back(8'(4 * idx));
        idx++;
      end
      if (done) done_seen = 1;
    end
    req_valid = 0;
    chk("prog_done", 32'(done), 32'(1));
    chk("prog_writes", 32'(n_wr), 32'(exp_n));
    chk("prog_count", 32'(count), 32'(exp_n));
    chk("prog_err_ill", 32'(err_illegal), 32'(e_ill));
    chk("prog_err_imm", 32'(err_imm), 32'(e_imm));
    chk("prog_err_full", 32'(err_full), 32'(!has_last));
  endtask

  initial begin
    vt[0]  = '{4'd0,  5'd3,  5'd1,  5'd2, 32'd0,        32'h002081B3, 1'b0, 1'b0};
    vt[1]  = '{4'd8,  5'd5,  5'd0,  5'd0, 32'hFFFFFFFF, 32'hFFF00293, 1'b0, 1'b0};
    vt[2]  = '{4'd11, 5'd0,  5'd1,  5'd2, 32'hFFFFFFF8, 32'hFE209CE3, 1'b0, 1'b0};
    vt[3]  = '{4'd12, 5'd1,  5'd0,  5'd0, 32'd16,       32'h010000EF, 1'b0, 1'b0};
    vt[4]  = '{4'd10, 5'd0,  5'd1,  5'd2, 32'd4,        32'h00208223, 1'b0, 1'b0};
    vt[5]  = '{4'd1,  5'd4,  5'd5,  5'd6, 32'd0,        32'h40628233, 1'b0, 1'b0};
    vt[6]  = '{4'd2,  5'd1,  5'd2,  5'd3, 32'd0,        32'h003170B3, 1'b0, 1'b0};
    vt[7]  = '{4'd5,  5'd2,  5'd3,  5'd0, 32'd40,       32'h00819113, 1'b0, 1'b1};
    vt[8]  = '{4'd6,  5'd7,  5'd8,  5'd0, 32'd31,       32'h01F45393, 1'b0, 1'b0};
    vt[9]  = '{4'd9,  5'd10, 5'd11, 5'd0, 32'hFFFFFFFC, 32'hFFC5C503, 1'b0, 1'b0};
    vt[10] = '{4'd11, 5'd0,  5'd1,  5'd2, 32'd7,        32'h00209363, 1'b0, 1'b1};
    vt[11] = '{4'd7,  5'd31, 5'd31, 5'd0, 32'd2047,     32'h7FFFFF93, 1'b0, 1'b0};
    vt[12] = '{4'd12, 5'd0,  5'd0,  5'd0, 32'hFFF00000, 32'h8000006F, 1'b0, 1'b0};
    vt[13] = '{4'd8,  5'd1,  5'd0,  5'd0, 32'd3000,     32'hBB800093, 1'b0, 1'b1};
    vt[14] = '{4'd14, 5'd1,  5'd2,  5'd3, 32'd0,        32'h00000013, 1'b1, 1'b0};
    vt[15] = '{4'd8,  5'd1,  5'd0,  5'd0, 32'hFFFFF7FF, 32'h7FF00093, 1'b0, 1'b1};

    rst_n = 0; start = 0; req_valid = 0; mem_ready = 0;
    set_req(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    #1;
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_errs", {29'd0, err_illegal, err_imm, err_full}, 0);

    // Single-word programs from the vector table.
    for (int i = 0; i < 16; i++) begin
      do_start();
      set_req(vt[i].op, vt[i].rd, vt[i].rs1, vt[i].rs2, vt[i].imm, 1);
      req_valid = 1; mem_ready = 1;
      #1 chk("vec_ready", 32'(req_ready), 1);
      @(negedge clk);
      req_valid = 0;
      #1;
      chk("vec_we", 32'(mem_we), 1);
      chk("vec_addr", 32'(mem_addr), 0);
      chk($sformatf("vec_word[%0d]", i), mem_wdata, vt[i].word);
      @(negedge clk);
      #1;
      chk("vec_done", 32'(done), 1);
      chk("vec_count", 32'(count), 1);
      chk($sformatf("vec_err_ill[%0d]", i), 32'(err_illegal), 32'(vt[i].ill));
      chk($sformatf("vec_err_imm[%0d]", i), 32'(err_imm), 32'(vt[i].bad));
      chk("vec_err_full", 32'(err_full), 0);
    end

    // Stall on the first write, start ignored during LOAD, then back-to-back.
    do_start();
    set_req(0, 3, 1, 2, 0, 0); req_valid = 1; mem_ready = 0;
    #1 chk("a_ready0", 32'(req_ready), 1);
    @(negedge clk);
    set_req(8, 5, 0, 0, -1, 1);
    #1;
    chk("a_we", 32'(mem_we), 1);
    chk("a_addr0", 32'(mem_addr), 0);
    chk("a_word0", mem_wdata, 32'h002081B3);
    chk("a_stall_ready", 32'(req_ready), 0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      start = (k == 0);
      #1;
      chk("a_hold_addr", 32'(mem_addr), 0);
      chk("a_hold_word", mem_wdata, 32'h002081B3);
      chk("a_hold_ready", 32'(req_ready), 0);
    end
    @(negedge clk);
    start = 0; mem_ready = 1;
    #1 chk("a_resume_ready", 32'(req_ready), 1);
    @(negedge clk);
    req_valid = 0;
    #1;
    chk("a_we1", 32'(mem_we), 1);
    chk("a_addr1", 32'(mem_addr), 4);
    chk("a_word1", mem_wdata, 32'hFFF00293);
    chk("a_last_ready", 32'(req_ready), 0);
    @(negedge clk);
    #1;
    chk("a_done", 32'(done), 1);
    chk("a_count", 32'(count), 2);
    chk("a_we_off", 32'(mem_we), 0);
    chk("a_errs", {29'd0, err_illegal, err_imm, err_full}, 0);

    // Illegal op and out-of-range immediate are sticky until the next start.
    p_n = 2;
    p_op[0] = 14; p_rd[0] = 1; p_rs1[0] = 2; p_rs2[0] = 3; p_imm[0] = 0;    p_last[0] = 0;
    p_op[1] = 8;  p_rd[1] = 1; p_rs1[1] = 0; p_rs2[1] = 0; p_imm[1] = 3000; p_last[1] = 1;
    run_program(100);
    chk("b_err_ill", 32'(err_illegal), 1);
    chk("b_err_imm", 32'(err_imm), 1);
    do_start();
    #1;
    chk("b_ill_cleared", 32'(err_illegal), 0);
    chk("b_imm_cleared", 32'(err_imm), 0);
    chk("b_done_cleared", 32'(done), 0);

    // MAX_WORDS reached without last.
    p_n = MAXW + 1;
    for (int i = 0; i < p_n; i++) begin
      p_op[i] = 8; p_rd[i] = i + 1; p_rs1[i] = i; p_rs2[i] = 0; p_imm[i] = i; p_last[i] = 0;
    end
    run_program(100);
    chk("c_err_full", 32'(err_full), 1);
    chk("c_count", 32'(count), MAXW);
    chk("c_ready_after", 32'(req_ready), 0);

    // Asynchronous reset while a write is pending.
    do_start();
    set_req(8, 1, 0, 0, 5, 1); req_valid = 1; mem_ready = 0;
    @(negedge clk);
    req_valid = 0;
    #1 chk("d_we_before", 32'(mem_we), 1);
    #2 rst_n = 0;
    #1;
    chk("d_we_reset", 32'(mem_we), 0);
    chk("d_ready_reset", 32'(req_ready), 0);
    @(negedge clk);
    rst_n = 1; mem_ready = 1;
    #1;
    chk("d_count", 32'(count), 0);
    chk("d_addr", 32'(mem_addr), 0);
    chk("d_done", 32'(done), 0);
    p_n = 1;
    p_op[0] = 12; p_rd[0] = 1; p_rs1[0] = 0; p_rs2[0] = 0; p_imm[0] = 16; p_last[0] = 1;
    run_program(100);

    // Random programs against the reference model.
    for (int t = 0; t < 30; t++) begin
      bit has;
      has = ($urandom_range(3) != 0);
      p_n = has ? int'($urandom_range(1, MAXW)) : MAXW + 1;
      for (int i = 0; i < p_n; i++) begin
        p_op[i]  = int'($urandom_range(15));
        p_rd[i]  = int'($urandom_range(31));
        p_rs1[i] = int'($urandom_range(31));
        p_rs2[i] = int'($urandom_range(31));
        p_imm[i] = rand_imm();
        p_last[i] = has && (i == p_n - 1);
      end
      run_program(int'($urandom_range(40, 100)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
